mem_access: RTL
===============

# mem_access

Memory-access stage of the RISC-V core. It consumes the execute stage's ALU result (address or pass-through value) and store data, drives a single-outstanding request/acknowledge data-memory bus, and aligns and extends load data. It produces the write-back value and stalls upstream stages while a memory transaction is in flight.

## Interface
- `MAX_WAIT`, default 255: cycles in BUSY without `dmem_ack_i` before the transaction is abandoned (8-bit counter).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid_i`  in  1  execute-stage result valid this cycle.
- `ctrl_MemRead_i` / `ctrl_MemWrite_i`  in  1 each  load / store op. Both low means pass-through.
- `mem_size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `mem_unsigned_i`  in  1  zero-extend loads (LBU/LHU).
- `alu_result_i`  in  32  byte address, or pass-through value.
- `mem_write_data_i`  in  32  store data, in the low bits.
- `stall_o`  out  1  hold upstream pipeline registers (combinational).
- `wb_valid_o`  out  1  `wb_data_o` is valid (registered, one-cycle pulse).
- `wb_data_o`  out  32  load result or pass-through value.
- `misaligned_o` / `timeout_o`  out  1 each  one-cycle error pulses (registered).
- `dmem_req_o`, `dmem_we_o`  out  1 each  request, write enable.
- `dmem_addr_o`  out  32  word-aligned address (bits [1:0] = 0).
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  32  lane-replicated store data.
- `dmem_ack_i`  in  1  transaction complete. `dmem_rdata_i` is valid in the same cycle.
- `dmem_rdata_i`  in  32  read word.

## Operation
- FSM states are IDLE and BUSY. Reset puts the FSM in IDLE and drives every registered output and the wait counter to 0.
- Pass-through (IDLE, `ex_valid_i`, no memory op): next cycle `wb_valid_o`=1 and `wb_data_o`=`alu_result_i`. No stall.
- Alignment check in IDLE:
  - half requires addr[0]=0; word requires addr[1:0]=0; size 11 is always illegal.
  - On a violation: no request, `misaligned_o` pulses next cycle, `wb_valid_o` stays 0, `stall_o` stays 0.
- Accepted memory op in IDLE:
  - Latch address, size, unsigned flag and data.
  - Assert `stall_o` this cycle.
  - Go to BUSY. `dmem_req_o` is high from the next cycle.
- Store lanes:
  - byte: be = 1<<addr[1:0], wdata = {4{d[7:0]}}.
  - half: be = 0011 or 1100 by addr[1], wdata = {2{d[15:0]}}.
  - word: be = 1111, wdata = d.
  - Loads drive the same `be`, with `dmem_we_o`=0.
- BUSY:
  - Hold `dmem_req_o`, `we`, `addr`, `be` and `wdata` stable until ack.
  - `stall_o` = ~`dmem_ack_i`.
  - On ack: drop req next cycle, return to IDLE. For a load, `wb_valid_o`=1 next cycle with the selected lane, sign- or zero-extended. A store produces no `wb_valid_o`.
- Timeout: the wait counter increments each BUSY cycle without ack. When it reaches `MAX_WAIT`:
  - drop req, pulse `timeout_o`, return to IDLE;
  - `wb_valid_o`=0 and `stall_o` low that cycle.
- Simultaneous ack and counter reaching `MAX_WAIT`: ack wins, no timeout.
- `ex_valid_i` is ignored while in BUSY.
- Reset mid-transaction: return to IDLE, req low the cycle after `rst` is sampled. Any late ack while in IDLE is ignored.

## Timing
- Pass-through latency: 1 cycle.
- Memory op timeline:
  - accept at cycle 0;
  - `dmem_req_o` from cycle 1;
  - ack at cycle k ≥ 1;
  - `wb_valid_o` at k+1;
  - upstream advances at the end of cycle k.
- Minimum load stall: 1 cycle (ack at cycle 1 → stall only in cycle 0).
- Back-to-back operations: the next op can be accepted at cycle k+1.
- All `dmem_*` outputs and the wb/error outputs are registered. `stall_o` is the only combinational output.

## Structure
- `defines.v` holds:
  - `RegBus` widths;
  - size encodings: `SizeByte`, `SizeHalf`, `SizeWord`;
  - FSM state encodings: `MemIdle`, `MemBusy`.
- Sub-module `load_align`: combinational lane select plus sign/zero extension (rdata, addr[1:0], size, unsigned → 32-bit).
  - Reused by any future cache-fill path.

## Test plan
- Pass-through: `ex_valid_i`=1, no mem op, alu=0x1234 → next cycle `wb_valid_o`=1, `wb_data_o`=0x1234, `stall_o` always 0.
- LB, addr 0x103, rdata 0x80FF_FF7F, ack after 3 cycles:
  - `dmem_addr_o`=0x100, `be`=1000;
  - `wb_data_o`=0xFFFF_FF80;
  - LBU of the same access → 0x0000_0080.
- SH, addr 0x202, data 0xABCD:
  - `be`=1100, `wdata`=0xABCD_ABCD, `we`=1;
  - no `wb_valid_o`;
  - stall deasserts in the ack cycle.
- LW at 0x0000_0006 → `misaligned_o` pulse, no `dmem_req_o`, no stall. Size 11 at any address → same response.
- No ack with `MAX_WAIT`=4 → `timeout_o` after the 4th BUSY cycle, req drops.
  - Variant: ack arrives in that same cycle → normal completion, no timeout.
- Assert `rst` in BUSY → req low the next cycle, all outputs 0. An ack arriving afterwards produces no `wb_valid_o`.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, size codes, FSM states and store-lane helpers for the memory-access stage
package mem_access_pkg;
  localparam int REG_BUS = 32;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic {MEM_IDLE, MEM_BUSY} state_t;
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == 2'b11 || (size == SIZE_HALF && off[0]) || (size == SIZE_WORD && off != 2'b00);
  endfunction
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_BYTE ? 4'b0001 << off : size == SIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [REG_BUS-1:0] lane_wdata(input logic [1:0] size, input logic [REG_BUS-1:0] d);
    return size == SIZE_BYTE ? {4{d[7:0]}} : size == SIZE_HALF ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/mem_access_load_align.sv
// load_align: picks the addressed byte/half/word lane of rdata and sign- or zero-extends it to 32 bits
module load_align
  import mem_access_pkg::*;
(
  input  logic [REG_BUS-1:0] rdata,
  input  logic [1:0]         off,
  input  logic [1:0]         size,
  input  logic               uns,
  output logic [REG_BUS-1:0] data
);
  logic [REG_BUS-1:0] lane;
  always_comb begin
    lane = rdata >> {off, 3'b000};
    data = size == SIZE_BYTE ? {{24{~uns & lane[7]}}, lane[7:0]} :
           size == SIZE_HALF ? {{16{~uns & lane[15]}}, lane[15:0]} : rdata;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: RISC-V memory stage; ex_* in, single-outstanding dmem_* req/ack bus, wb_*/error pulses out, stall_o upstream
module mem_access
  import mem_access_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid_i,
  input  logic               ctrl_MemRead_i,
  input  logic               ctrl_MemWrite_i,
  input  logic [1:0]         mem_size_i,
  input  logic               mem_unsigned_i,
  input  logic [REG_BUS-1:0] alu_result_i,
  input  logic [REG_BUS-1:0] mem_write_data_i,
  output logic               stall_o,
  output logic               wb_valid_o,
  output logic [REG_BUS-1:0] wb_data_o,
  output logic               misaligned_o,
  output logic               timeout_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [REG_BUS-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [REG_BUS-1:0] dmem_wdata_o,
  input  logic               dmem_ack_i,
  input  logic [REG_BUS-1:0] dmem_rdata_i
);
  localparam logic [7:0] LIM = 8'(MAX_WAIT - 1);
  state_t state, state_n;
  logic [7:0] cnt;
  logic [1:0] off_q, size_q;
  logic uns_q, ld_q, idle, mem_op, bad, accept, done, tmo;
  logic [REG_BUS-1:0] ld_data;
  load_align u_align (
    .rdata(dmem_rdata_i),
    .off  (off_q),
    .size (size_q),
    .uns  (uns_q),
    .data (ld_data)
  );
  always_comb begin
    idle    = state == MEM_IDLE;
    mem_op  = ctrl_MemRead_i | ctrl_MemWrite_i;
    bad     = is_misaligned(mem_size_i, alu_result_i[1:0]);
    accept  = idle & ex_valid_i & mem_op & ~bad;
    done    = ~idle & dmem_ack_i;
    tmo     = ~idle & ~dmem_ack_i & (cnt == LIM);
    state_n = accept ? MEM_BUSY : (done | tmo) ? MEM_IDLE : state;
    stall_o = accept | (~idle & ~dmem_ack_i & ~tmo);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= MEM_IDLE;
      cnt          <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      ld_q         <= 1'b0;
      wb_valid_o   <= 1'b0;
      wb_data_o    <= '0;
      misaligned_o <= 1'b0;
      timeout_o    <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
    end else begin
      state        <= state_n;
      wb_valid_o   <= (idle & ex_valid_i & ~mem_op) | (done & ld_q);
      misaligned_o <= idle & ex_valid_i & mem_op & bad;
      timeout_o    <= tmo;
      if (idle & ex_valid_i & ~mem_op) wb_data_o <= alu_result_i;
      if (done & ld_q) wb_data_o <= ld_data;
      if (~idle) cnt <= cnt + 8'd1;
      if (done | tmo) dmem_req_o <= 1'b0;
      if (accept) begin
        cnt          <= '0;
        off_q        <= alu_result_i[1:0];
        size_q       <= mem_size_i;
        uns_q        <= mem_unsigned_i;
        ld_q         <= ~ctrl_MemWrite_i;
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= ctrl_MemWrite_i;
        dmem_addr_o  <= {alu_result_i[REG_BUS-1:2], 2'b00};
        dmem_be_o    <= lane_be(mem_size_i, alu_result_i[1:0]);
        dmem_wdata_o <= lane_wdata(mem_size_i, mem_write_data_i);
      end
    end
  end
endmodule
